// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: immediate-extension mode encodings.
package cpu_defs_pkg;

  localparam int EXT_MODE_W = 3;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO   = 3'd0,
    EXT_SIGN   = 3'd1,
    EXT_UPPER  = 3'd2,
    EXT_BRANCH = 3'd3,
    EXT_SHAMT  = 3'd4
  } ext_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: IMM_W raw field to DATA_W operand,
// with an error flag for reserved modes.
module imm_ext_core
  import cpu_defs_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic [IMM_W-1:0]      imm,
  output logic [DATA_W-1:0]     data,
  output logic                  err
);

  localparam int EXT_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] sext;

  assign sext = {{EXT_W{imm[IMM_W-1]}}, imm};

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ext_mode_e'(mode))
      EXT_ZERO:   data = {{EXT_W{1'b0}}, imm};
      EXT_SIGN:   data = sext;
      EXT_UPPER:  data = {imm, {EXT_W{1'b0}}};
      EXT_BRANCH: data = {sext[DATA_W-3:0], 2'b00};
      EXT_SHAMT:  data = {{(DATA_W-SHAMT_W){1'b0}}, imm[SHAMT_W-1:0]};
      default:    err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage: head output register plus one skid
// register behind a valid/ready handshake, with synchronous flush.
module imm_extend_pipe
  import cpu_defs_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_W-1:0]      Immediate,
  input  logic [EXT_MODE_W-1:0] ExtMode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     Out,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  logic [DATA_W-1:0] ext_data;
  logic              ext_err;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  skid_tag;
  logic              skid_err;
  logic              accept;
  logic              head_free;

  imm_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .SHAMT_W(SHAMT_W)
  ) u_core (
    .mode(ExtMode),
    .imm (Immediate),
    .data(ext_data),
    .err (ext_err)
  );

  // in_ready comes straight off the skid flop, so it never sees out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign head_free = !out_valid || out_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_valid  <= 1'b0;
      Out        <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (Flush) begin
      // Payload registers keep their contents; only the valids are squashed.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (head_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        Out        <= skid_data;
        out_tag    <= skid_tag;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        Out       <= ext_data;
        out_tag   <= in_tag;
        out_err   <= ext_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
      skid_err   <= ext_err;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus randomized
// traffic scored against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        CLK = 1'b0;
  logic        Reset, Flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_err;
  logic [15:0] Immediate;
  logic [2:0]  ExtMode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] Out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        err;
    logic [4:0]  tag;
    logic [31:0] data;
  } item_t;

  item_t q[$];

  imm_extend_pipe #(.IMM_W(16), .DATA_W(32), .SHAMT_W(5), .TAG_W(5)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Flush    (Flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Immediate(Immediate),
    .ExtMode  (ExtMode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (Out),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  always #5 CLK = ~CLK;

  function automatic item_t ref_ext(logic [15:0] imm, logic [2:0] mode, logic [4:0] tag);
    item_t  r;
    longint s;
    longint v;
    s     = longint'($signed(imm));
    r.err = 1'b0;
    r.tag = tag;
    case (mode)
      3'd0:    v = longint'(imm);
      3'd1:    v = s;
      3'd2:    v = longint'(imm) * 65536;
      3'd3:    v = s * 4;
      3'd4:    v = longint'(imm) % 32;
      default: begin v = 0; r.err = 1'b1; end
    endcase
    r.data = v[31:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic cycle(input logic iv, input logic [15:0] imm, input logic [2:0] mode,
                       input logic [4:0] tag, input logic ordy, input logic fl);
    bit acc, rel;
    in_valid  = iv;
    Immediate = imm;
    ExtMode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    Flush     = fl;
    acc = iv && (q.size() < 2);
    rel = ordy && (q.size() > 0);
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(ref_ext(imm, mode, tag));
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("Out", Out, q[0].data);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      chk("out_err", 32'(out_err), 32'(q[0].err));
    end
  endtask

  task automatic do_reset(input int n);
    Reset    = 1'b1;
    Flush    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
    Reset = 1'b0;
    q.delete();
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Immediate = '0; ExtMode = '0; in_tag = '0;

    do_reset(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Out", Out, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // Directed extension modes, back to back with out_ready=1.
    cycle(1, 16'h8007, 3'd0, 5'd1, 1, 0); chk("zero_8007", Out, 32'h00008007);
    cycle(1, 16'h8007, 3'd1, 5'd2, 1, 0); chk("sign_8007", Out, 32'hFFFF8007);
    cycle(1, 16'h000A, 3'd1, 5'd3, 1, 0); chk("sign_000A", Out, 32'h0000000A);
    cycle(1, 16'h1234, 3'd2, 5'd4, 1, 0); chk("upper_1234", Out, 32'h12340000);
    cycle(1, 16'hFFFF, 3'd3, 5'd5, 1, 0); chk("branch_FFFF", Out, 32'hFFFFFFFC);
    cycle(1, 16'hFFFF, 3'd4, 5'd6, 1, 0); chk("shamt_FFFF", Out, 32'h0000001F);
    cycle(1, 16'h5555, 3'd6, 5'd7, 1, 0);
    chk("rsvd_Out", Out, 32'd0);
    chk("rsvd_err", 32'(out_err), 32'd1);
    cycle(0, 16'h0, 3'd0, 5'd0, 1, 0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: skid fills, third item held off, order preserved.
    cycle(1, 16'h0001, 3'd0, 5'd1, 0, 0);
    cycle(1, 16'h0002, 3'd0, 5'd2, 0, 0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cycle(1, 16'h0003, 3'd0, 5'd3, 0, 0);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    chk("bp_hold_Out", Out, 32'd1);
    cycle(1, 16'h0003, 3'd0, 5'd3, 1, 0);
    chk("bp_second", 32'(out_tag), 32'd2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    cycle(1, 16'h0003, 3'd0, 5'd3, 1, 0);
    chk("bp_third", 32'(out_tag), 32'd3);
    cycle(0, 16'h0, 3'd0, 5'd0, 1, 0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full throughput: one result per cycle for 20 cycles.
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        cycle(1, 16'(i), 3'd0, 5'(i), 1, 0);
        if (out_valid && out_tag == 5'(i)) seen++;
      end
      chk("thru_count", 32'(seen), 32'd20);
    end
    cycle(0, 16'h0, 3'd0, 5'd0, 1, 0);

    // Flush with head and skid full and an item on offer.
    cycle(1, 16'h0077, 3'd0, 5'd7, 0, 0);
    cycle(1, 16'h0088, 3'd0, 5'd8, 0, 0);
    cycle(1, 16'h0099, 3'd0, 5'd9, 0, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_Out_kept", Out, 32'h00000077);
    cycle(0, 16'h0, 3'd0, 5'd0, 1, 0);
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)),
            5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Reset mid-backpressure clears everything including Out.
    cycle(1, 16'h1111, 3'd1, 5'd11, 0, 0);
    cycle(1, 16'h2222, 3'd1, 5'd12, 0, 0);
    do_reset(1);
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_Out", Out, 32'd0);
    chk("rst2_tag", 32'(out_tag), 32'd0);
    chk("rst2_ready", 32'(in_ready), 32'd1);
    cycle(0, 16'h0, 3'd0, 5'd0, 1, 0);
    chk("rst2_no_skid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
